// File: rtl/adc_input_pkg.sv
// Shared types and defaults for the ADC lane deskew engine.
// Pure declarations: no latency, no flow control.
package adc_input_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    NEXT_TAP,
    APPLY,
    NEXT_LANE,
    DONE
  } state_t;

  localparam int DEF_TAP_W  = 5;
  localparam int DEF_N_TAPS = 32;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_lane_window_search.sv
// Tracks the current and widest run of passing taps and derives the window centre.
// Window registers update one cycle after upd; centre is combinational from best; no backpressure.
module adc_lane_window_search #(
  parameter int TAP_W = 5
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             clear,
  input  logic             upd,
  input  logic             pass,
  input  logic [TAP_W:0]   tap,
  output logic [TAP_W:0]   best_len,
  output logic [TAP_W-1:0] centre
);

  localparam logic [TAP_W:0] ONE = 1;

  logic [TAP_W:0] cur_start;
  logic [TAP_W:0] cur_len;
  logic [TAP_W:0] best_start;
  logic [TAP_W:0] nxt_start;
  logic [TAP_W:0] nxt_len;

  always_comb begin
    nxt_start = (cur_len == '0) ? tap : cur_start;
    nxt_len   = cur_len + ONE;
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (upd) begin
      if (pass) begin
        cur_start <= nxt_start;
        cur_len   <= nxt_len;
        // strict compare keeps the earliest of equally wide windows
        if (nxt_len > best_len) begin
          best_start <= nxt_start;
          best_len   <= nxt_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

  assign centre = TAP_W'(best_start + ((best_len - ONE) >> 1));

endmodule

// File: rtl/adc_lane_deskew.sv
// Per-lane IDELAY tap sweep against a training word; loads the centre of the widest passing window.
// data_out is data_in delayed one cycle; a full calibration takes N_LANES*(N_TAPS*(SETTLE+CHECK+2)+2) cycles; no backpressure.
module adc_lane_deskew
  import adc_input_pkg::*;
#(
  parameter int N_LANES       = 8,
  parameter int TAP_W         = DEF_TAP_W,
  parameter int N_TAPS        = DEF_N_TAPS,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_LEN     = 64
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst,
  input  logic                       start,
  input  logic [2*N_LANES-1:0]       train_word,
  input  logic [2*N_LANES-1:0]       data_in,
  output logic [N_LANES-1:0]         idelay_ld,
  output logic [N_LANES*TAP_W-1:0]   idelay_cntvalue,
  output logic                       busy,
  output logic                       done,
  output logic [N_LANES-1:0]         lane_err,
  output logic [N_LANES*TAP_W-1:0]   tap_result,
  output logic [2*N_LANES-1:0]       data_out,
  output logic                       data_valid
);

  localparam int LW      = lane_idx_w(N_LANES);
  localparam int CNT_MAX = (CHECK_LEN > SETTLE_CYCLES) ? CHECK_LEN : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TAP_W:0] TAP_ONE  = 1;
  localparam logic [LW-1:0]  LANE_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [LW-1:0]    lane;
  logic [LW-1:0]    lane_nx;
  logic [TAP_W:0]   tap;
  logic [CNT_W-1:0] cnt;
  logic             match;
  logic             lane_eq;
  logic [TAP_W-1:0] cnt_q [N_LANES];
  logic [TAP_W-1:0] res_q [N_LANES];

  logic             win_clr;
  logic [TAP_W:0]   win_best_len;
  logic [TAP_W-1:0] win_centre;

  assign lane_nx = lane + LANE_ONE;
  assign lane_eq = (data_in[{lane, 1'b0} +: 2] == train_word[{lane, 1'b0} +: 2]);
  assign win_clr = (state == NEXT_LANE) || (start && (state == IDLE || state == DONE));

  adc_lane_window_search #(.TAP_W(TAP_W)) u_win (
    .adc_clk  (adc_clk),
    .adc_rst  (adc_rst),
    .clear    (win_clr),
    .upd      (state == NEXT_TAP),
    .pass     (match),
    .tap      (tap),
    .best_len (win_best_len),
    .centre   (win_centre)
  );

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state      <= IDLE;
      lane       <= '0;
      tap        <= '0;
      cnt        <= '0;
      match      <= 1'b0;
      idelay_ld  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_err   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      idelay_ld <= '0;
      data_out  <= data_in;
      // tap loads are issued on entry to LOAD so the strobe and value coincide with that state
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            lane       <= '0;
            tap        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            data_valid <= 1'b0;
            lane_err   <= '0;
            cnt_q[0]   <= '0;
            idelay_ld[0] <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            match <= 1'b1;
            state <= CHECK;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        CHECK: begin
          match <= match & lane_eq;
          if (cnt == CNT_W'(CHECK_LEN - 1)) begin
            state <= NEXT_TAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        NEXT_TAP: begin
          if (tap == (TAP_W + 1)'(N_TAPS - 1)) begin
            state <= APPLY;
          end else begin
            tap             <= tap + TAP_ONE;
            cnt_q[lane]     <= TAP_W'(tap + TAP_ONE);
            idelay_ld[lane] <= 1'b1;
            state           <= LOAD;
          end
        end
        APPLY: begin
          idelay_ld[lane] <= 1'b1;
          if (win_best_len != '0) begin
            cnt_q[lane] <= win_centre;
            res_q[lane] <= win_centre;
          end else begin
            cnt_q[lane]    <= '0;
            res_q[lane]    <= '0;
            lane_err[lane] <= 1'b1;
          end
          state <= NEXT_LANE;
        end
        NEXT_LANE: begin
          if (lane == LW'(N_LANES - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            data_valid <= ~|lane_err;
          end else begin
            lane               <= lane_nx;
            tap                <= '0;
            cnt_q[lane_nx]     <= '0;
            idelay_ld[lane_nx] <= 1'b1;
            state              <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign idelay_cntvalue[g*TAP_W +: TAP_W] = cnt_q[g];
    assign tap_result[g*TAP_W +: TAP_W]      = res_q[g];
  end

endmodule
